// File: rtl/lut6_pkg.sv
// lut6_pkg: shared widths, write-FSM state type and beat-count helper for the LUT6 mask loader
package lut6_pkg;
  localparam int MASK_W = 64;
  localparam int LUT_IN_W = 6;
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} wr_state_e;
  function automatic int beats_per_mask(input int beat_w);
    return MASK_W / beat_w;
  endfunction
endpackage

// File: rtl/lut6_mask_rd.sv
// lut6_mask_rd: registered 64:1 mask read; ports clk/rst_n, en (lookup strobe), hit (index in range), mask, din (LUT address) -> dout (held when en is low)
module lut6_mask_rd
  import lut6_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                hit,
  input  logic [MASK_W-1:0]   mask,
  input  logic [LUT_IN_W-1:0] din,
  output logic                dout
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dout <= 1'b0;
    else if (en) dout <= hit && mask[din];
endmodule

// File: rtl/lut6_mask_loader.sv
// lut6_mask_loader: runtime-writable bank of 6-input LUT masks; ports: wr_* beat stream (valid/ready, idx on first beat, LSB-first data, last), lk_* registered lookup -> out_valid/out_dout, busy, sticky err_frame, commit_pulse
module lut6_mask_loader
  import lut6_pkg::*;
#(
  parameter int                NUM_LUTS   = 8,
  parameter int                BEAT_W     = 16,
  parameter logic [MASK_W-1:0] RESET_MASK = 64'h80000000_00000000,
  localparam int               IDX_W      = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [BEAT_W-1:0]   wr_data,
  input  logic                wr_last,
  input  logic                lk_valid,
  input  logic [IDX_W-1:0]    lk_idx,
  input  logic [LUT_IN_W-1:0] lk_din,
  output logic                out_valid,
  output logic                out_dout,
  output logic                busy,
  output logic                err_frame,
  output logic                commit_pulse
);
  localparam int BPM = beats_per_mask(BEAT_W);
  localparam int CNT_W = (BPM > 1) ? $clog2(BPM) : 1;
  localparam logic [IDX_W:0] LUTS = (IDX_W + 1)'(NUM_LUTS);
  localparam logic [CNT_W-1:0] FINAL = CNT_W'(BPM - 1);
  wr_state_e state, next;
  logic run, acc, is_final, bad, lk_hit;
  logic [CNT_W-1:0] cnt, pos;
  logic [IDX_W-1:0] idx_q, lk_sel;
  logic [MASK_W-1:0] shadow, shadow_wr;
  logic [MASK_W-1:0] masks [NUM_LUTS];
  // run keeps wr_ready low while in reset and until the first edge after release
  assign acc = wr_valid && wr_ready;
  assign pos = (state == IDLE) ? '0 : cnt;
  assign is_final = pos == FINAL;
  // wr_last must coincide exactly with the final beat position
  assign bad = acc && (wr_last != is_final);
  always_comb begin
    shadow_wr = shadow;
    shadow_wr[pos*BEAT_W +: BEAT_W] = wr_data;
  end
  always_comb next = (state == COMMIT) ? IDLE : !acc ? state : bad ? IDLE : is_final ? COMMIT : LOAD;
  always_comb begin
    wr_ready = run && state != COMMIT;
    busy = state != IDLE;
    commit_pulse = state == COMMIT;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      run <= 1'b0;
      cnt <= '0;
      idx_q <= '0;
      shadow <= '0;
      err_frame <= 1'b0;
    end else begin
      state <= next;
      run <= 1'b1;
      if (acc) cnt <= (next == LOAD) ? pos + CNT_W'(1) : '0;
      if (acc && state == IDLE) idx_q <= wr_idx;
      shadow <= (state == COMMIT || bad) ? '0 : acc ? shadow_wr : shadow;
      err_frame <= err_frame || bad;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NUM_LUTS; i++) masks[i] <= RESET_MASK;
    else if (state == COMMIT && {1'b0, idx_q} < LUTS) masks[idx_q] <= shadow;
  assign lk_hit = {1'b0, lk_idx} < LUTS;
  assign lk_sel = lk_hit ? lk_idx : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) out_valid <= 1'b0;
    else out_valid <= lk_valid;
  lut6_mask_rd u_rd (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (lk_valid),
    .hit  (lk_hit),
    .mask (masks[lk_sel]),
    .din  (lk_din),
    .dout (out_dout)
  );
endmodule

// File: tb/tb_lut6_mask_loader.sv
// tb_lut6_mask_loader: table vectors, hand sequences and random traffic checked against a frame-level model
module tb_lut6_mask_loader;
  localparam int N = 8;
  localparam logic [63:0] RST_M = 64'h80000000_00000000;
  logic clk = 1'b0, rst_n = 1'b1;
  logic wr_valid = 1'b0, wr_last = 1'b0, lk_valid = 1'b0;
  logic [2:0] wr_idx = '0, lk_idx = '0;
  logic [15:0] wr_data = '0;
  logic [5:0] lk_din = '0;
  logic wr_ready, out_valid, out_dout, busy, err_frame, commit_pulse;
  int n_chk = 0, n_fail = 0, n_cp = 0;
  logic [63:0] m_mask [N];
  logic [15:0] q [$];
  logic [2:0] m_fidx, m_pidx;
  logic [63:0] m_pdata;
  bit m_pend, m_run, m_err, m_ov, m_dout;
  typedef struct {logic [2:0] idx; logic [5:0] din; logic exp;} vec_t;
  vec_t vec [6];

  lut6_mask_loader dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
    .wr_data(wr_data), .wr_last(wr_last), .lk_valid(lk_valid), .lk_idx(lk_idx), .lk_din(lk_din),
    .out_valid(out_valid), .out_dout(out_dout), .busy(busy), .err_frame(err_frame),
    .commit_pulse(commit_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_mask[i] = RST_M;
    q.delete();
    m_pend = 0; m_run = 0; m_err = 0; m_ov = 0; m_dout = 0;
  endtask

  task automatic chk_all();
    chk("wr_ready", wr_ready, m_run && !m_pend);
    chk("busy", busy, q.size() > 0 || m_pend);
    chk("commit_pulse", commit_pulse, m_pend);
    chk("err_frame", err_frame, m_err);
    chk("out_valid", out_valid, m_ov);
    chk("out_dout", out_dout, m_dout);
  endtask

  // one clock: model the edge from frame rules, then compare DUT after the edge
  task automatic cyc();
    bit acc;
    acc = m_run && !m_pend && wr_valid;
    if (lk_valid) m_dout = m_mask[lk_idx][lk_din];
    m_ov = lk_valid;
    if (m_pend) begin
      m_mask[m_pidx] = m_pdata;
      m_pend = 0;
    end
    if (acc) begin
      if (q.size() == 0) m_fidx = wr_idx;
      q.push_back(wr_data);
      if (wr_last && q.size() == 4) begin
        m_pdata = {q[3], q[2], q[1], q[0]};
        m_pidx = m_fidx;
        m_pend = 1;
        q.delete();
      end else if (wr_last || q.size() == 4) begin
        m_err = 1;
        q.delete();
      end
    end
    m_run = 1;
    @(posedge clk);
    #1;
    if (commit_pulse) n_cp++;
    chk_all();
  endtask

  task automatic look(input logic [2:0] idx, input logic [5:0] din);
    lk_valid = 1; lk_idx = idx; lk_din = din;
    cyc();
  endtask

  // present one beat until the DUT takes it
  task automatic beat(input logic [2:0] idx, input logic [15:0] d, input logic last);
    bit taken;
    int guard;
    guard = 0;
    wr_valid = 1; wr_idx = idx; wr_data = d; wr_last = last;
    do begin
      taken = wr_ready;
      cyc();
      guard++;
    end while (!taken && guard < 20);
    if (!taken) chk("beat_accept_timeout", 0, 1);
    wr_valid = 0; wr_last = 0;
  endtask

  initial begin
    int cp0, ovc, cycles;
    m_reset();
    #1 rst_n = 0;
    #2 chk_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    // reset mask contents
    look(0, 63); chk("rst_din63", out_dout, 1);
    look(0, 0); chk("rst_din0", out_dout, 0);
    lk_valid = 0;
    cyc();
    // load idx 3, then collide a lookup with the commit cycle
    cp0 = n_cp;
    beat(3, 16'hAAAA, 0); beat(3, 16'h5555, 0); beat(3, 16'hFFFF, 0);
    wr_valid = 1; wr_idx = 3; wr_data = 16'h0000; wr_last = 1;
    cyc();
    wr_valid = 0; wr_last = 0;
    chk("commit_pulse_on", commit_pulse, 1);
    look(3, 1); chk("collide_old", out_dout, 0); chk("commit_pulse_off", commit_pulse, 0);
    look(3, 1); chk("after_commit_new", out_dout, 1);
    chk("one_commit_pulse", n_cp - cp0, 1);
    vec[0] = '{3, 0, 0}; vec[1] = '{3, 1, 1}; vec[2] = '{3, 16, 1};
    vec[3] = '{3, 17, 0}; vec[4] = '{3, 32, 1}; vec[5] = '{3, 48, 0};
    for (int i = 0; i < 6; i++) begin
      look(vec[i].idx, vec[i].din);
      chk($sformatf("table%0d", i), out_dout, vec[i].exp);
    end
    // early wr_last -> framing error, target unchanged
    lk_valid = 0;
    cp0 = n_cp;
    beat(4, 16'h1111, 0); beat(4, 16'h2222, 1);
    cyc();
    chk("err_set", err_frame, 1);
    chk("err_no_commit", n_cp - cp0, 0);
    look(4, 63); chk("err_mask_keep63", out_dout, 1);
    look(4, 0); chk("err_mask_keep0", out_dout, 0);
    lk_valid = 0;
    beat(6, 16'hBEEF, 0); beat(6, 16'h1234, 0); beat(6, 16'h0F0F, 0); beat(6, 16'hC001, 1);
    cyc(); cyc();
    chk("err_sticky", err_frame, 1);
    chk("good_after_err_commit", n_cp - cp0, 1);
    // random handshake gaps, wr_idx switched mid-frame, lookups every cycle
    ovc = 0; cycles = 0;
    for (int f = 0; f < 3; f++)
      for (int b = 0; b < 4; b++) begin
        bit taken;
        int guard;
        guard = 0;
        while ($urandom_range(0, 1) == 1 && guard < 8) begin
          wr_valid = 0; lk_valid = 1; lk_idx = 3'($urandom); lk_din = 6'($urandom);
          cyc(); cycles++; ovc += int'(out_valid); guard++;
        end
        wr_valid = 1; wr_idx = (b < 2) ? 3'd2 : 3'd5; wr_data = 16'($urandom); wr_last = (b == 3);
        guard = 0;
        do begin
          taken = wr_ready;
          lk_valid = 1; lk_idx = 3'($urandom); lk_din = 6'($urandom);
          cyc(); cycles++; ovc += int'(out_valid); guard++;
        end while (!taken && guard < 20);
        if (!taken) chk("rand_accept_timeout", 0, 1);
        wr_valid = 0; wr_last = 0;
      end
    cyc(); cycles++; ovc += int'(out_valid);
    chk("out_valid_continuous", ovc, cycles);
    for (int d = 0; d < 64; d++) look(2, 6'(d));
    look(5, 63); chk("idx5_untouched63", out_dout, 1);
    look(5, 0); chk("idx5_untouched0", out_dout, 0);
    // reset in the middle of a frame
    lk_valid = 0;
    beat(1, 16'hFFFF, 0); beat(1, 16'hFFFF, 0);
    chk("midload_busy", busy, 1);
    #3 rst_n = 0;
    #1 m_reset();
    chk_all();
    chk("midreset_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < N; i++) begin
      look(3'(i), 63); look(3'(i), 0);
    end
    lk_valid = 0;
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lut6_mask_loader.md
Name: lut6_mask_loader

Overview:
- Runtime-writable bank of NUM_LUTS 6-input lookup tables for the network datapath (CRC/scrambler tap selection, header-match functions).
- Writer side: a mask is streamed in as 16-bit beats over a valid/ready handshake, assembled in a shadow register, then committed atomically.
- Reader side: a registered 6-input lookup against the committed mask.
- Masks can be changed in-system without resynthesis; SIM_EMULATE behaviour of the fixed primitive is reproduced by the read path.

Parameters:
- NUM_LUTS, 8, number of independent 64-bit masks
- BEAT_W, 16, write beat width; must divide 64 (16 gives 4 beats per mask)
- IDX_W, $clog2(NUM_LUTS), LUT index width (derived, not overridable)
- RESET_MASK, 64'h80000000_00000000, value every mask takes at reset

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  write beat valid
- wr_ready  out  1  write beat accepted when wr_valid&&wr_ready
- wr_idx  in  IDX_W  target LUT; sampled on first beat only
- wr_data  in  BEAT_W  mask beat, LSB-first (beat 0 = mask[15:0])
- wr_last  in  1  marks final beat of a mask
- lk_valid  in  1  lookup request
- lk_idx  in  IDX_W  LUT to read
- lk_din  in  6  LUT address
- out_valid  out  1  lookup result valid
- out_dout  out  1  mask[lk_idx][lk_din]
- busy  out  1  write frame in progress or committing
- err_frame  out  1  sticky framing error; cleared only by reset
- commit_pulse  out  1  one-cycle strobe when a mask is committed

Behaviour:
- Reset, asynchronous, rst_n low:
  - all masks = RESET_MASK; shadow = 0; beat counter = 0
  - FSM = IDLE; wr_ready=0, out_valid=0, out_dout=0, busy=0, err_frame=0, commit_pulse=0
  - outputs take these values immediately and release synchronously on the first clk edge after rst_n rises
  - reset mid-frame discards the partial shadow; committed masks revert to RESET_MASK
- Write FSM:
  - IDLE (wr_ready=1, busy=0): on accept, latch wr_idx, write beat 0 into shadow, cnt=1 -> LOAD. If wr_last is set on that beat (BEAT_W<64) -> framing error.
  - LOAD (wr_ready=1, busy=1): each accept writes shadow[cnt*BEAT_W +: BEAT_W], cnt++.
    - wr_last on beat 64/BEAT_W-1 -> COMMIT.
    - wr_last earlier -> error.
    - final beat without wr_last -> error.
    - wr_idx changes in LOAD are ignored.
  - COMMIT (wr_ready=0, busy=1): mask[idx_latched] <= shadow; commit_pulse=1 for this cycle; -> IDLE next cycle.
  - Framing error handling: err_frame<=1, shadow discarded, no commit -> IDLE. Remaining beats of the bad frame are each treated as new frames; software must reset or resend after checking err_frame.
- Throughput: 64/BEAT_W beats plus 1 COMMIT cycle per mask, so 5 cycles at the default.
- Lookup:
  - 1-cycle latency: if lk_valid at edge N, out_valid=1 and out_dout=mask[lk_idx][lk_din] after edge N.
  - out_valid=0 otherwise; out_dout holds its last value.
  - Fully pipelined: one lookup per cycle, independent of write activity.
- Collision: a lookup in the COMMIT cycle to the same index returns the OLD mask (read-before-write). The next cycle returns the new mask.
- Out-of-range index (NUM_LUTS not a power of 2): wr_idx>=NUM_LUTS commits nothing but still pulses commit_pulse. lk_idx>=NUM_LUTS returns 0.

Decomposition:
- Shared package lut6_pkg:
  - MASK_W=64
  - LUT_IN_W=6
  - write-FSM state enum {IDLE, LOAD, COMMIT}
  - beats_per_mask function (64/BEAT_W)
- One natural sub-module: lut6_mask_rd, a registered 64:1 mux per read (mask, din -> dout with 1-cycle register). The top holds the FSM, shadow and mask array.

Test Plan:
- Reset only: lookup idx 0, din 63 -> out_dout=1 one cycle later; din 0 -> 0 (RESET_MASK).
- Load idx 3 with beats 16'hAAAA,16'h5555,16'hFFFF,16'h0000 (last on 4th) -> commit_pulse once; lookups din=0/1/16/17/32/48 -> 0/1/1/0/1/0.
- Lookup idx 3 din 1 in the COMMIT cycle with old mask RESET_MASK -> returns 0; same lookup next cycle -> 1.
- wr_last on beat 2 -> err_frame=1, no commit_pulse, idx target mask unchanged; err_frame stays set through a later valid load.
- Toggle wr_valid randomly with wr_idx changed mid-frame from 2 to 5 -> mask 2 updated, mask 5 untouched; back-to-back lookups every cycle show out_valid continuously high.
- Assert rst_n low mid-LOAD -> outputs reset immediately, all masks read RESET_MASK, busy=0.
